id_fwd_stage: RTL and testbench

//  Second-generation MIPS decode stage. Decodes one instruction per beat and resolves

---
 rtl/id_fwd_stage.sv | 170 +++++++++++++++++
 tb/tb_id_fwd_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/id_fwd_stage.sv
// id_fwd_stage: MIPS decode with parametrised operand forwarding, load-use interlock and a valid/ready ID/EX register
module id_fwd_stage #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_pc,
    input  logic [31:0]               in_inst,
    input  logic                      flush,
    output logic [ADDR_W-1:0]         rf_raddr1,
    output logic [ADDR_W-1:0]         rf_raddr2,
    input  logic [DATA_W-1:0]         rf_rdata1,
    input  logic [DATA_W-1:0]         rf_rdata2,
    input  logic [NUM_FWD-1:0]        fwd_wreg,
    input  logic [NUM_FWD*ADDR_W-1:0] fwd_wd,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
    input  logic                      fwd0_is_load,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [7:0]                out_aluop,
    output logic [2:0]                out_alusel,
    output logic [DATA_W-1:0]         out_reg1,
    output logic [DATA_W-1:0]         out_reg2,
    output logic [ADDR_W-1:0]         out_wd,
    output logic                      out_wreg,
    output logic [31:0]               out_pc,
    output logic                      out_illegal,
    output logic [CNT_W-1:0]          stall_cnt
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state, state_nx;
    logic [5:0] op, funct;
    logic [4:0] sa;
    logic [ADDR_W-1:0] rs, rt, rd, ld_wd, wd;
    logic [7:0] aluop;
    logic [2:0] alusel;
    logic wreg, re1, re2, illegal, hazard, accept;
    logic [DATA_W-1:0] imm, op1, op2;

    assign op        = in_inst[31:26];
    assign funct     = in_inst[5:0];
    assign sa        = in_inst[10:6];
    assign rs        = ADDR_W'(in_inst[25:21]);
    assign rt        = ADDR_W'(in_inst[20:16]);
    assign rd        = ADDR_W'(in_inst[15:11]);
    assign rf_raddr1 = rs;
    assign rf_raddr2 = rt;

    always_comb begin
        aluop   = 8'h00;
        alusel  = 3'b000;
        wd      = '0;
        wreg    = 1'b0;
        re1     = 1'b0;
        re2     = 1'b0;
        imm     = '0;
        illegal = 1'b0;
        if (op == 6'h00 && rs == '0 && (funct == 6'h00 || funct == 6'h02 || funct == 6'h03)) begin
            aluop  = funct == 6'h00 ? 8'h7C : {2'b00, funct};
            alusel = 3'b010;
            wd     = rd;
            wreg   = 1'b1;
            re2    = 1'b1;
            imm    = DATA_W'(sa);
        end else if (op == 6'h00 && sa == 5'd0) begin
            case (funct)
                6'h24, 6'h25, 6'h26, 6'h27, 6'h04, 6'h06, 6'h07: begin
                    aluop  = funct == 6'h04 ? 8'h7C : funct == 6'h06 ? 8'h02 :
                             funct == 6'h07 ? 8'h03 : {2'b00, funct};
                    alusel = funct[5] ? 3'b001 : 3'b010;
                    wd     = rd;
                    wreg   = 1'b1;
                    re1    = 1'b1;
                    re2    = 1'b1;
                end
                6'h0F:   illegal = 1'b0;
                default: illegal = 1'b1;
            endcase
        end else begin
            case (op)
                6'h0C, 6'h0D, 6'h0E: begin
                    aluop  = op == 6'h0C ? 8'h24 : op == 6'h0D ? 8'h25 : 8'h26;
                    alusel = 3'b001;
                    wd     = rt;
                    wreg   = 1'b1;
                    re1    = 1'b1;
                    imm    = DATA_W'(in_inst[15:0]);
                end
                6'h0F: begin
                    aluop  = 8'h25;
                    alusel = 3'b001;
                    wd     = rt;
                    wreg   = 1'b1;
                    re1    = 1'b1;
                    imm    = DATA_W'({in_inst[15:0], 16'h0000});
                end
                6'h23: begin
                    aluop  = 8'hE3;
                    alusel = 3'b111;
                    wd     = rt;
                    wreg   = 1'b1;
                    re1    = 1'b1;
                    imm    = {{(DATA_W-16){in_inst[15]}}, in_inst[15:0]};
                end
                6'h33:   illegal = 1'b0;
                default: illegal = 1'b1;
            endcase
        end
    end

    // Scan oldest to youngest so the lowest matching channel wins
    always_comb begin
        op1 = rf_rdata1;
        op2 = rf_rdata2;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (fwd_wreg[k] && fwd_wd[k*ADDR_W +: ADDR_W] == rs) op1 = fwd_wdata[k*DATA_W +: DATA_W];
            if (fwd_wreg[k] && fwd_wd[k*ADDR_W +: ADDR_W] == rt) op2 = fwd_wdata[k*DATA_W +: DATA_W];
        end
        if (rs == '0) op1 = '0;
        if (rt == '0) op2 = '0;
        if (!re1) op1 = imm;
        if (!re2) op2 = imm;
    end

    assign ld_wd    = fwd_wd[ADDR_W-1:0];
    assign hazard   = in_valid && fwd0_is_load && fwd_wreg[0] && ld_wd != '0 &&
                      ((re1 && ld_wd == rs) || (re2 && ld_wd == rt));
    assign out_valid = state == FULL;
    assign in_ready  = !rst && !flush && !hazard && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_nx = state;
        if (accept) state_nx = FULL;
        else if (flush || out_ready) state_nx = EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            out_aluop   <= 8'h00;
            out_alusel  <= 3'b000;
            out_reg1    <= '0;
            out_reg2    <= '0;
            out_wd      <= '0;
            out_wreg    <= 1'b0;
            out_pc      <= '0;
            out_illegal <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                out_aluop   <= aluop;
                out_alusel  <= alusel;
                out_reg1    <= op1;
                out_reg2    <= op2;
                out_wd      <= wd;
                out_wreg    <= wreg;
                out_pc      <= in_pc;
                out_illegal <= illegal;
            end
            if (hazard && !flush && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_id_fwd_stage.sv
// tb_id_fwd_stage: directed spec scenarios plus random traffic against a behavioural decode/handshake model
module tb_id_fwd_stage;
    localparam int DW = 32, AW = 5, NF = 2, CW = 4, CMAX = (1 << CW) - 1;
    logic clk = 1'b0;
    logic rst, in_valid, in_ready, flush, fwd0_is_load, out_valid, out_ready, out_wreg, out_illegal;
    logic [31:0] in_pc, in_inst, out_pc;
    logic [AW-1:0] rf_raddr1, rf_raddr2, out_wd;
    logic [DW-1:0] rf_rdata1, rf_rdata2, out_reg1, out_reg2;
    logic [NF-1:0] fwd_wreg;
    logic [NF*AW-1:0] fwd_wd;
    logic [NF*DW-1:0] fwd_wdata;
    logic [7:0] out_aluop;
    logic [2:0] out_alusel;
    logic [CW-1:0] stall_cnt;
    int total = 0, bad = 0, m_cnt = 0;
    logic m_valid = 1'b0, was_rst = 1'b0;

    typedef struct packed {
        logic [7:0] aluop; logic [2:0] alusel; logic [31:0] reg1; logic [31:0] reg2;
        logic [4:0] wd; logic wreg; logic [31:0] pc; logic illegal;
    } ent_t;
    typedef struct packed {
        logic [7:0] aluop; logic [2:0] alusel; logic [4:0] wd; logic wreg; logic illegal;
        logic u1; logic u2; logic [31:0] imm;
    } dec_t;
    ent_t m_e = '0;

    always #5 clk = ~clk;

    id_fwd_stage #(.DATA_W(DW), .ADDR_W(AW), .NUM_FWD(NF), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_inst(in_inst), .flush(flush), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .fwd_wreg(fwd_wreg), .fwd_wd(fwd_wd),
        .fwd_wdata(fwd_wdata), .fwd0_is_load(fwd0_is_load), .out_valid(out_valid),
        .out_ready(out_ready), .out_aluop(out_aluop), .out_alusel(out_alusel),
        .out_reg1(out_reg1), .out_reg2(out_reg2), .out_wd(out_wd), .out_wreg(out_wreg),
        .out_pc(out_pc), .out_illegal(out_illegal), .stall_cnt(stall_cnt)
    );

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic dec_t decode(logic [31:0] i);
        dec_t d;
        logic [5:0] op, fn;
        logic [4:0] rs, rt, rd, sa;
        d = '0; op = i[31:26]; fn = i[5:0]; rs = i[25:21]; rt = i[20:16]; rd = i[15:11]; sa = i[10:6];
        if (op == 0 && rs == 0 && fn inside {6'h00, 6'h02, 6'h03}) begin
            d.aluop = fn == 6'h00 ? 8'h7C : fn == 6'h02 ? 8'h02 : 8'h03;
            d.alusel = 3'b010; d.wd = rd; d.wreg = 1; d.u2 = 1; d.imm = 32'(sa);
        end else if (op == 0 && sa == 0 && fn inside {6'h24, 6'h25, 6'h26, 6'h27}) begin
            d.aluop = {2'b00, fn}; d.alusel = 3'b001; d.wd = rd; d.wreg = 1; d.u1 = 1; d.u2 = 1;
        end else if (op == 0 && sa == 0 && fn inside {6'h04, 6'h06, 6'h07}) begin
            d.aluop = fn == 6'h04 ? 8'h7C : fn == 6'h06 ? 8'h02 : 8'h03;
            d.alusel = 3'b010; d.wd = rd; d.wreg = 1; d.u1 = 1; d.u2 = 1;
        end else if ((op == 0 && sa == 0 && fn == 6'h0F) || op == 6'h33) begin
            d = '0;
        end else if (op inside {6'h0C, 6'h0D, 6'h0E}) begin
            d.aluop = op == 6'h0C ? 8'h24 : op == 6'h0D ? 8'h25 : 8'h26;
            d.alusel = 3'b001; d.wd = rt; d.wreg = 1; d.u1 = 1; d.imm = {16'h0, i[15:0]};
        end else if (op == 6'h0F) begin
            d.aluop = 8'h25; d.alusel = 3'b001; d.wd = rt; d.wreg = 1; d.u1 = 1; d.imm = i[15:0] * 32'h10000;
        end else if (op == 6'h23) begin
            d.aluop = 8'hE3; d.alusel = 3'b111; d.wd = rt; d.wreg = 1; d.u1 = 1; d.imm = 32'(signed'(i[15:0]));
        end else begin
            d.illegal = 1;
        end
        return d;
    endfunction

    function automatic logic [31:0] opnd(logic u, logic [4:0] a, logic [31:0] imm, logic [31:0] rf);
        if (!u) return imm;
        if (a == 0) return 0;
        for (int k = 0; k < NF; k++)
            if (fwd_wreg[k] && fwd_wd[k*AW +: AW] == a) return fwd_wdata[k*DW +: DW];
        return rf;
    endfunction

    function automatic logic haz(dec_t d, logic [31:0] i);
        logic [4:0] l;
        l = fwd_wd[AW-1:0];
        return in_valid && fwd0_is_load && fwd_wreg[0] && l != 0 &&
               ((d.u1 && l == i[25:21]) || (d.u2 && l == i[20:16]));
    endfunction

    function automatic logic [31:0] rnd_inst();
        logic [4:0] rs, rt, rd, sa;
        logic [15:0] imm;
        int s;
        logic [5:0] fn;
        rs = 5'($urandom_range(7)); rt = 5'($urandom_range(7)); rd = 5'($urandom_range(7));
        sa = 5'($urandom_range(3)); imm = 16'($urandom); s = $urandom_range(6);
        fn = s == 0 ? 6'h24 : s == 1 ? 6'h25 : s == 2 ? 6'h26 : s == 3 ? 6'h27 : s == 4 ? 6'h04 : s == 5 ? 6'h06 : 6'h07;
        case ($urandom_range(9))
            0, 1:    return {6'h00, rs, rt, rd, 5'd0, fn};
            2:       return {11'h0, rt, rd, sa, s[0] ? 6'h02 : (s[1] ? 6'h03 : 6'h00)};
            3:       return {6'h0C + 6'($urandom_range(2)), rs, rt, imm};
            4:       return {6'h0F, 5'd0, rt, imm};
            5:       return {6'h23, rs, rt, imm};
            6:       return s < 2 ? 32'h0000000F : s < 4 ? {6'h33, rs, rt, imm} : 32'h0;
            7:       return {6'h3F, rs, rt, imm};
            default: return $urandom;
        endcase
    endfunction

    task automatic step();
        dec_t d;
        ent_t e;
        logic h, rdy, acc;
        #3;
        d = decode(in_inst);
        h = haz(d, in_inst);
        rdy = !rst && !flush && !h && (!m_valid || out_ready);
        acc = in_valid && rdy;
        check("in_ready", in_ready, rdy);
        check("rf_raddr1", rf_raddr1, in_inst[25:21]);
        check("rf_raddr2", rf_raddr2, in_inst[20:16]);
        e = '{d.aluop, d.alusel, opnd(d.u1, in_inst[25:21], d.imm, rf_rdata1),
              opnd(d.u2, in_inst[20:16], d.imm, rf_rdata2), d.wd, d.wreg, in_pc, d.illegal};
        was_rst = rst;
        @(posedge clk);
        #1;
        if (was_rst) begin
            m_valid = 0; m_e = '0; m_cnt = 0;
        end else begin
            if (acc) begin m_valid = 1; m_e = e; end
            else if (flush || out_ready) m_valid = 0;
            if (h && !flush && m_cnt < CMAX) m_cnt++;
        end
        check("out_valid", out_valid, m_valid);
        check("stall_cnt", stall_cnt, 64'(m_cnt));
        if (m_valid || was_rst) begin
            check("aluop", out_aluop, m_e.aluop);
            check("alusel", out_alusel, m_e.alusel);
            check("reg1", out_reg1, m_e.reg1);
            check("reg2", out_reg2, m_e.reg2);
            check("wd", out_wd, m_e.wd);
            check("wreg", out_wreg, m_e.wreg);
            check("pc", out_pc, m_e.pc);
            check("illegal", out_illegal, m_e.illegal);
        end
    endtask

    initial begin
        rst = 1; in_valid = 0; in_pc = 0; in_inst = 0; flush = 0; out_ready = 1; fwd0_is_load = 0;
        rf_rdata1 = 32'h11111111; rf_rdata2 = 32'h22222222; fwd_wreg = 0; fwd_wd = 0; fwd_wdata = 0;
        @(posedge clk);
        #1;
        step(); step();
        rst = 0;
        in_valid = 1; in_pc = 32'h100; in_inst = 32'h34011100;
        step();
        check("ori_aluop", out_aluop, 8'h25); check("ori_reg2", out_reg2, 32'h1100); check("ori_wd", out_wd, 1);
        in_pc = 32'h104; in_inst = 32'h00221825; fwd_wreg = 2'b11;
        fwd_wd = {5'd2, 5'd1}; fwd_wdata = {32'h0F0F, 32'hAAAA};
        step();
        check("or_reg1", out_reg1, 32'hAAAA); check("or_reg2", out_reg2, 32'h0F0F);
        fwd_wd = {5'd1, 5'd1}; fwd_wdata = {32'h5555, 32'hAAAA};
        step();
        check("or_prio", out_reg1, 32'hAAAA);
        in_inst = 32'h00021825; fwd_wd = {5'd0, 5'd0};
        step();
        check("zero_src", out_reg1, 0);
        in_pc = 32'h108; in_inst = 32'h00862824; fwd_wreg = 2'b01; fwd_wd = {5'd0, 5'd4};
        fwd_wdata = {32'h0, 32'hBEEF}; fwd0_is_load = 1;
        step();
        check("lu_bubble", out_valid, 0);
        step();
        check("lu_cnt", stall_cnt, 2);
        fwd0_is_load = 0;
        step();
        check("lu_fwd", out_reg1, 32'hBEEF);
        out_ready = 0; in_pc = 32'h10C; in_inst = 32'h34020022;
        repeat (3) step();
        check("hold_pc", out_pc, 32'h108);
        out_ready = 1;
        step(); step();
        check("b2b", out_valid, 1);
        flush = 1;
        step();
        check("flush", out_valid, 0);
        flush = 0; in_inst = 32'hFC000000;
        step();
        check("illegal_flag", out_illegal, 1); check("illegal_wreg", out_wreg, 0);
        in_inst = 32'h00862824; fwd_wd = {5'd0, 5'd4}; fwd0_is_load = 1;
        step(); step();
        rst = 1;
        step();
        check("rst_stall_cnt", stall_cnt, 0); check("rst_valid", out_valid, 0);
        rst = 0;
        repeat (CMAX + 2) step();
        check("sat", stall_cnt, CMAX);
        fwd0_is_load = 0;
        repeat (3000) begin
            rst = $urandom_range(99) < 2; flush = $urandom_range(99) < 8;
            in_valid = $urandom_range(9) < 8; out_ready = $urandom_range(9) < 7;
            in_pc = $urandom; in_inst = rnd_inst(); rf_rdata1 = $urandom; rf_rdata2 = $urandom;
            fwd_wreg = 2'($urandom); fwd_wd = {5'($urandom_range(7)), 5'($urandom_range(7))};
            fwd_wdata = {32'($urandom), 32'($urandom)}; fwd0_is_load = $urandom_range(3) == 0;
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
